// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
//   Bit-serial adder sequencer. A single full-adder cell (two half adders plus
//   an OR) is time-shared across all WIDTH bit positions. The operands are
//   shifted through it LSB-first and the carry is kept in a flop.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operands present
//   in_ready   controller can accept operands (IDLE only)
//   op_a       operand A [WIDTH]
//   op_b       operand B [WIDTH]
//   cin        carry-in, captured with the operands
//   out_valid  sum/cout valid
//   out_ready  consumer takes the result
//   sum        registered sum [WIDTH]
//   cout       registered carry-out
//   busy       high in RUN or DONE
// -----------------------------------------------------------------------------

module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] shift_a_reg;
    logic [WIDTH-1:0] shift_b_reg;
    logic [WIDTH-1:0] sum_sh_reg;
    logic [WIDTH-1:0] sum_sh_next;
    logic             carry_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;
    logic             out_valid_reg;
    logic             in_ready_reg;
    logic             busy_reg;

    // Full-adder cell: propagate/generate from the first half adder, then the
    // second half adder folds in the running carry.
    logic p_bit, g_bit, bit_s, t_bit, carry_next, last_bit;

    half_adder ha_ab (
        .a (shift_a_reg[0]),
        .b (shift_b_reg[0]),
        .s (p_bit),
        .c (g_bit)
    );

    half_adder ha_pc (
        .a (p_bit),
        .b (carry_reg),
        .s (bit_s),
        .c (t_bit)
    );

    assign carry_next = g_bit | t_bit;
    assign last_bit   = (cnt_reg == CW'(WIDTH - 1));

    // Sum register shifts right; the new bit enters at the MSB so that after
    // WIDTH steps the first computed bit has arrived at bit 0.
    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_sum_shift
            assign sum_sh_next[gi] = sum_sh_reg[gi + 1];
        end
    endgenerate
    assign sum_sh_next[WIDTH-1] = bit_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            shift_a_reg   <= '0;
            shift_b_reg   <= '0;
            sum_sh_reg    <= '0;
            carry_reg     <= 1'b0;
            cnt_reg       <= '0;
            sum_reg       <= '0;
            cout_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        shift_a_reg  <= op_a;
                        shift_b_reg  <= op_b;
                        carry_reg    <= cin;
                        cnt_reg      <= '0;
                        state_reg    <= RUN;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                    end
                end
                RUN: begin
                    shift_a_reg <= shift_a_reg >> 1;
                    shift_b_reg <= shift_b_reg >> 1;
                    sum_sh_reg  <= sum_sh_next;
                    carry_reg   <= carry_next;
                    cnt_reg     <= cnt_reg + CW'(1);
                    if (last_bit) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    // First DONE edge publishes the result; only then is the
                    // output handshake honoured, so sum/cout never move while
                    // out_valid is high.
                    if (!out_valid_reg) begin
                        sum_reg       <= sum_sh_reg;
                        cout_reg      <= carry_reg;
                        out_valid_reg <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                        in_ready_reg  <= 1'b1;
                        busy_reg      <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign sum       = sum_reg;
    assign cout      = cout_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
//   Directed and randomized checks of serial_add_ctrl with WIDTH=8.
//   Inputs change on the falling edge; outputs are sampled on the falling edge
//   or 1ns after the rising edge.
// -----------------------------------------------------------------------------

module tb_serial_add_ctrl;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    int total = 0;
    int bad   = 0;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            bad++;
            $display("FAIL reset_flags: in_ready/out_valid/busy=%b required 100", {in_ready, out_valid, busy});
        end
        total++;
        if ({cout, sum} !== 9'h000) begin
            bad++;
            $display("FAIL reset_result: {cout,sum}=%h required 000", {cout, sum});
        end
        @(negedge clk);
        rst = 1'b0;
        $display("reset: in_ready=%b out_valid=%b busy=%b sum=%h cout=%b", in_ready, out_valid, busy, sum, cout);
    endtask

    // One full operation: accept, measure latency, check result, hand off.
    // With scramble set, the operand inputs change every RUN cycle.
    task automatic test_add(input logic [7:0] a, input logic [7:0] b, input logic c,
                            input logic [7:0] es, input logic ec, input bit scramble,
                            input string name);
        int edges;
        @(negedge clk);
        op_a = a; op_b = b; cin = c; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        total++;
        if ({busy, in_ready} !== 2'b10) begin
            bad++;
            $display("FAIL %s_accept: busy/in_ready=%b required 10", name, {busy, in_ready});
        end
        edges = 1;
        while (out_valid !== 1'b1 && edges < 40) begin
            if (scramble) begin
                op_a = 8'($urandom); op_b = 8'($urandom); cin = 1'($urandom);
            end
            @(posedge clk);
            #1;
            edges++;
        end
        // edges counts rising edges after the accepting one (accept = edge 0)
        edges = edges - 1;
        total++;
        if (edges !== 9) begin
            bad++;
            $display("FAIL %s_latency: edges=%0d required 9", name, edges);
        end
        total++;
        if (sum !== es) begin
            bad++;
            $display("FAIL %s_sum: sum=%h required %h", name, sum, es);
        end
        total++;
        if (cout !== ec) begin
            bad++;
            $display("FAIL %s_cout: cout=%b required %b", name, cout, ec);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        total++;
        if ({out_valid, in_ready, busy, cout, sum} !== {3'b010, ec, es}) begin
            bad++;
            $display("FAIL %s_handoff: ov/ir/busy=%b {cout,sum}=%h required 010 %h",
                     name, {out_valid, in_ready, busy}, {cout, sum}, {ec, es});
        end
        $display("%s: %h+%h+%b -> sum=%h cout=%b latency=%0d", name, a, b, c, sum, cout, edges);
    endtask

    task automatic test_backpressure();
        int edges;
        int errs;
        @(negedge clk);
        op_a = 8'hC3; op_b = 8'h5E; cin = 1'b1; in_valid = 1'b1;   // C3+5E+1 = 122
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        edges = 0;
        while (out_valid !== 1'b1 && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL bp_timeout: out_valid=%b required 1", out_valid);
        end
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid = 1'b1; op_a = 8'($urandom); op_b = 8'($urandom); cin = 1'($urandom);
            if ({out_valid, in_ready, busy, cout, sum} !== {3'b101, 9'h122}) errs++;
        end
        total++;
        if (errs !== 0) begin
            bad++;
            $display("FAIL bp_hold: %0d bad cycles, last ov/ir/busy=%b {cout,sum}=%h required 101 122",
                     errs, {out_valid, in_ready, busy}, {cout, sum});
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        total++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            bad++;
            $display("FAIL bp_release: ov/ir/busy=%b required 010", {out_valid, in_ready, busy});
        end
        $display("backpressure: held 20 cycles, {cout,sum}=%h", {cout, sum});
    endtask

    task automatic test_reset_mid_run();
        int stray;
        @(negedge clk);
        op_a = 8'h5A; op_b = 8'h3C; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({in_ready, out_valid, busy, cout, sum} !== {3'b100, 9'h000}) begin
            bad++;
            $display("FAIL midrst_state: ir/ov/busy=%b {cout,sum}=%h required 100 000",
                     {in_ready, out_valid, busy}, {cout, sum});
        end
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        for (int i = 0; i < 2 * WIDTH; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stray++;
        end
        total++;
        if (stray !== 0) begin
            bad++;
            $display("FAIL midrst_stray: out_valid high %0d cycles required 0", stray);
        end
        $display("reset_mid_run: aborted, stray out_valid cycles=%0d", stray);
    endtask

    task automatic test_back_to_back();
        logic [8:0] exp_q[$];
        logic [8:0] exp_v;
        logic [7:0] ra, rb;
        logic       rc;
        int sent = 0;
        int recv = 0;
        int cyc  = 0;
        while ((sent < 1000 || recv < 1000) && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            // A result handed off at the next rising edge is checked now.
            out_ready = ($urandom_range(0, 3) != 0);
            if (out_valid === 1'b1 && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL b2b_extra: {cout,sum}=%h with no pending operation", {cout, sum});
                end else begin
                    exp_v = exp_q.pop_front();
                    if ({cout, sum} !== exp_v) begin
                        bad++;
                        $display("FAIL b2b_result_%0d: {cout,sum}=%h required %h", recv, {cout, sum}, exp_v);
                    end
                    $display("b2b %0d: {cout,sum}=%h", recv, {cout, sum});
                end
                recv++;
            end
            // in_valid is also raised while busy; those cycles must be ignored.
            in_valid = 1'b0;
            if (sent < 1000 && $urandom_range(0, 2) != 0) begin
                ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
                op_a = ra; op_b = rb; cin = rc; in_valid = 1'b1;
                if (in_ready === 1'b1) begin
                    exp_q.push_back({1'b0, ra} + {1'b0, rb} + {8'h00, rc});
                    sent++;
                end
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        total++;
        if (recv !== 1000 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL b2b_count: received=%0d pending=%0d required 1000 and 0", recv, exp_q.size());
        end
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op_a = '0; op_b = '0; cin = 1'b0;
        test_reset();
        test_add(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b0, "basic");
        test_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "carry_ff_01");
        test_add(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, "carry_ff_cin");
        test_add(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, "carry_cin_only");
        test_add(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, "max_operands");
        test_add(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b1, "stability");
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder sequencer. Accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake.
- Pushes the operands LSB-first through a single full-adder stage built from two half-adder cells plus an OR, with a registered carry.
- Returns the WIDTH-bit sum and carry-out over a second valid/ready handshake.
- Trades latency for area. It is the controller that time-shares one adder cell across all bit positions.

Parameters:
- WIDTH, 8, operand/sum width in bits. Legal range is 1..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands present
- in_ready  output  1  controller can accept operands (high only in IDLE)
- op_a  input  WIDTH  operand A
- op_b  input  WIDTH  operand B
- cin  input  1  carry-in, captured with the operands
- out_valid  output  1  sum/cout valid
- out_ready  input  1  consumer takes the result
- sum  output  WIDTH  registered sum
- cout  output  1  registered carry-out
- busy  output  1  high in RUN or DONE

Behaviour:
- States: IDLE, RUN, DONE. Encoding is free; the state is registered.
- Reset, applied on any edge with rst=1 and taking priority over everything:
  - state=IDLE, in_ready=1, out_valid=0, busy=0.
  - sum=0, cout=0, internal shift registers, bit counter and carry flop all 0.
- Reset mid-RUN or mid-DONE aborts the operation. No out_valid for the aborted operation appears afterwards.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: load shift_a=op_a, shift_b=op_b, carry=cin, cnt=0, then go to RUN.
  - in_valid=0 means stay in IDLE.
  - Operands are sampled only on the accepting edge; later op_a/op_b/cin changes are ignored.
- RUN, each edge:
  - s = shift_a[0]^shift_b[0]^carry, computed via half-adder cells.
  - carry <= (shift_a[0]&shift_b[0]) | (carry&(shift_a[0]^shift_b[0])).
  - shift_a and shift_b shift right by 1.
  - The sum shift register shifts right with s inserted at the MSB.
  - cnt increments.
  - On the edge where cnt==WIDTH-1: go to DONE, drive sum with the fully shifted result and cout with the final carry.
  - in_ready=0 throughout; in_valid is ignored.
- Latency: out_valid rises exactly WIDTH+1 edges after the accepting edge (WIDTH RUN edges plus the DONE entry register). With WIDTH=8, acceptance at edge 0 gives out_valid high after edge 9.
- DONE:
  - out_valid=1; sum and cout are stable.
  - On an edge with out_ready=1: go to IDLE and set out_valid=0.
  - out_ready=0 means hold indefinitely, with sum/cout unchanged.
  - in_ready goes high the cycle after the output handshake. There is no same-cycle accept of new operands.
- sum and cout keep their last value after the output handshake until the next operation completes. They never change while out_valid=1.
- Counter width is clog2(WIDTH)+1 bits. No wrap occurs within one operation.
- WIDTH=1: exactly one RUN cycle, then DONE.
- Arithmetic: {cout,sum} == op_a + op_b + cin, modulo 2^(WIDTH+1). The result is exact with no overflow loss.
- busy = (state != IDLE).

Test Plan:
- Basic add, WIDTH=8: op_a=0x5A, op_b=0x3C, cin=0 -> sum=0x96, cout=0. out_valid rises exactly 9 edges after the accepting edge.
- Carry chain: 0xFF+0x01, cin=0 -> sum=0x00, cout=1. Then 0xFF+0x00, cin=1 -> sum=0x00, cout=1. Then 0x00+0x00, cin=1 -> sum=0x01, cout=0.
- Backpressure: hold out_ready=0 for 20 cycles in DONE.
  - Required: out_valid stays 1, sum and cout are constant, in_ready=0.
  - Raising in_valid with new operands meanwhile has no effect.
  - Releasing out_ready gives IDLE on the next edge and in_ready=1.
- Operand stability: change op_a/op_b every cycle during RUN after accepting 0x12+0x34 -> result is still 0x46, cout=0.
- Reset mid-operation: assert rst for 1 cycle at RUN cycle 4 -> next cycle state IDLE, in_ready=1, out_valid=0, sum=0, cout=0. No stray out_valid appears within 2*WIDTH cycles afterwards.
- Randomized back-to-back: 1000 random operands with random in_valid/out_ready gaps, checked against a reference model -> every result matches {cout,sum}=a+b+cin, with one result per accepted input, in order.
